// File: rtl/fm_diff_encoder_pkg.sv
// Shared constants and types for the feature-map row-differential encoder.
// Output beat struct bundles value, flags and address so the register stage loads in one go.
package fm_diff_encoder_pkg;

    localparam int PSUM_W = 20;
    localparam int DATA_W = 8;
    localparam int W_MAX  = 64;
    localparam int ADDR_W = 16;
    localparam int LB_AW  = $clog2(W_MAX);

    typedef enum logic {
        FDE_IDLE,
        FDE_RUN
    } fde_state_e;

    typedef struct packed {
        logic signed [DATA_W:0] data;
        logic                   raw;
        logic                   zero;
        logic [ADDR_W-1:0]      addr;
    } fde_out_t;

endpackage

// File: rtl/fm_diff_encoder_if.sv
// Config, psum input and encoded output handshake bundle for fm_diff_encoder.
// slave = encoder side, master = producer/consumer side.
interface fm_diff_encoder_if;
    import fm_diff_encoder_pkg::*;

    logic                     cfg_valid;
    logic                     cfg_ready;
    logic [7:0]               w_num_i;
    logic [7:0]               h_num_i;
    logic [7:0]               c_num_i;
    logic                     bit_mode_i;
    logic [3:0]               shift_i;

    logic                     psum_valid;
    logic                     psum_ready;
    logic signed [PSUM_W-1:0] psum_data;

    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W:0]   out_data;
    logic                     out_raw;
    logic                     out_zero;
    logic [ADDR_W-1:0]        out_addr;
    logic                     layer_done;

    modport slave (
        input  cfg_valid, w_num_i, h_num_i, c_num_i, bit_mode_i, shift_i,
        input  psum_valid, psum_data, out_ready,
        output cfg_ready, psum_ready,
        output out_valid, out_data, out_raw, out_zero, out_addr, layer_done
    );

    modport master (
        output cfg_valid, w_num_i, h_num_i, c_num_i, bit_mode_i, shift_i,
        output psum_valid, psum_data, out_ready,
        input  cfg_ready, psum_ready,
        input  out_valid, out_data, out_raw, out_zero, out_addr, layer_done
    );

endinterface

// File: rtl/fm_line_buf.sv
// One-row line buffer: combinational read, synchronous write at the same index.
// A read in the write cycle returns the old contents; no reset (row 0 always reseeds it).
module fm_line_buf #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    idx,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[idx];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

endmodule

// File: rtl/fm_diff_encoder.sv
// ReLU + shift-requantise psums, emit row-differential values with sparsity flags; latency 1 cycle.
// Backpressure: output register holds while out_ready is low and psum_ready drops until it drains.
module fm_diff_encoder
    import fm_diff_encoder_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    fm_diff_encoder_if.slave   bus
);

    fde_state_e        state_q, state_d;
    logic [7:0]        w_q, h_q, c_q;
    logic              bm_q;
    logic [3:0]        sh_q;
    logic [7:0]        col_q, row_q, ch_q;
    logic [ADDR_W-1:0] addr_q;
    logic              fed_last_q;
    logic              out_last_q;
    logic              out_valid_q;
    logic              done_q;
    fde_out_t          out_q;

    logic              cfg_fire, psum_fire, out_fire, at_last;
    logic [PSUM_W-1:0] relu, shifted;
    logic [DATA_W-1:0] q_max, q, lb_rd;
    fde_out_t          beat;

    assign bus.cfg_ready  = (state_q == FDE_IDLE);
    assign bus.psum_ready = (state_q == FDE_RUN) && !fed_last_q && (!out_valid_q || bus.out_ready);

    assign cfg_fire  = bus.cfg_valid && bus.cfg_ready;
    assign psum_fire = bus.psum_valid && bus.psum_ready;
    assign out_fire  = out_valid_q && bus.out_ready;
    assign at_last   = (col_q == w_q) && (row_q == h_q) && (ch_q == c_q);

    // Quantiser and diff; lb_rd is the previous row's value because the write lands at the edge.
    always_comb begin
        relu    = bus.psum_data[PSUM_W-1] ? '0 : bus.psum_data;
        shifted = relu >> sh_q;
        q_max   = bm_q ? DATA_W'(15) : DATA_W'(255);
        q       = (shifted > {{(PSUM_W-DATA_W){1'b0}}, q_max}) ? q_max : shifted[DATA_W-1:0];
        beat.raw  = (row_q == 8'd0);
        beat.data = beat.raw ? {1'b0, q} : ({1'b0, q} - {1'b0, lb_rd});
        beat.zero = (beat.data == '0);
        beat.addr = addr_q;
    end

    fm_line_buf #(
        .DEPTH (W_MAX),
        .WIDTH (DATA_W)
    ) u_line_buf (
        .clk   (clk),
        .we    (psum_fire),
        .idx   (col_q[LB_AW-1:0]),
        .wdata (q),
        .rdata (lb_rd)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            FDE_IDLE: if (cfg_fire) state_d = FDE_RUN;
            FDE_RUN:  if (out_fire && out_last_q) state_d = FDE_IDLE;
            default:  state_d = FDE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FDE_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q         <= '0;
            h_q         <= '0;
            c_q         <= '0;
            bm_q        <= 1'b0;
            sh_q        <= '0;
            col_q       <= '0;
            row_q       <= '0;
            ch_q        <= '0;
            addr_q      <= '0;
            fed_last_q  <= 1'b0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            out_q       <= '0;
        end else begin
            done_q <= out_fire && out_last_q;
            if (cfg_fire) begin
                w_q        <= bus.w_num_i;
                h_q        <= bus.h_num_i;
                c_q        <= bus.c_num_i;
                bm_q       <= bus.bit_mode_i;
                sh_q       <= bus.shift_i;
                col_q      <= '0;
                row_q      <= '0;
                ch_q       <= '0;
                addr_q     <= '0;
                fed_last_q <= 1'b0;
            end
            if (psum_fire) begin
                out_q       <= beat;
                out_valid_q <= 1'b1;
                out_last_q  <= at_last;
                addr_q      <= addr_q + 1'b1;
                if (at_last) fed_last_q <= 1'b1;
                if (col_q == w_q) begin
                    col_q <= '0;
                    if (row_q == h_q) begin
                        row_q <= '0;
                        ch_q  <= ch_q + 1'b1;
                    end else begin
                        row_q <= row_q + 1'b1;
                    end
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_q.data;
    assign bus.out_raw    = out_q.raw;
    assign bus.out_zero   = out_q.zero;
    assign bus.out_addr   = out_q.addr;
    assign bus.layer_done = done_q;

    // Rows wider than the line buffer would alias columns.
    assert property (@(posedge clk) disable iff (rst) cfg_fire |-> ({24'd0, bus.w_num_i} < W_MAX));

endmodule

// File: tb/tb_fm_diff_encoder.sv
module tb_fm_diff_encoder;
    import fm_diff_encoder_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fm_diff_encoder_if fif();

    fm_diff_encoder dut (
        .clk (clk),
        .rst (rst),
        .bus (fif)
    );

    typedef struct {
        int data;
        bit raw;
        bit zero;
        int addr;
        bit last;
    } exp_t;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    int   pq[$];
    int   data_log[$];
    int   raw_log[$];
    int   zero_log[$];

    int m_w, m_h, m_c, m_sh;
    bit m_bm;
    int m_col, m_row, m_ch, m_addr;
    bit m_busy = 1'b0;
    bit m_fed_all = 1'b0;
    bit done_exp = 1'b0;
    int lb [W_MAX];

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            m_busy    = 1'b0;
            m_fed_all = 1'b0;
            done_exp  = 1'b0;
        end else begin
            exp_t e;
            chk("layer_done", fif.layer_done, done_exp);
            chk("cfg_ready", fif.cfg_ready, !m_busy);
            done_exp = 1'b0;
            if (fif.cfg_valid && !m_busy) begin
                m_w = fif.w_num_i; m_h = fif.h_num_i; m_c = fif.c_num_i;
                m_bm = fif.bit_mode_i; m_sh = fif.shift_i;
                m_col = 0; m_row = 0; m_ch = 0; m_addr = 0;
                m_busy = 1'b1; m_fed_all = 1'b0;
            end
            if (fif.out_valid && fif.out_ready) begin
                chk("out_beat_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("out_data", $signed(fif.out_data), e.data);
                    chk("out_raw", fif.out_raw, e.raw);
                    chk("out_zero", fif.out_zero, e.zero);
                    chk("out_addr", fif.out_addr, e.addr);
                    data_log.push_back($signed(fif.out_data));
                    raw_log.push_back(fif.out_raw);
                    zero_log.push_back(fif.out_zero);
                    if (e.last) begin
                        done_exp = 1'b1;
                        m_busy   = 1'b0;
                    end
                end
            end
            if (fif.psum_valid && fif.psum_ready) begin
                int p, s, q;
                chk("psum_accept_legal", m_busy && !m_fed_all, 1);
                p = fif.psum_data;
                s = (p < 0) ? 0 : (p >>> m_sh);
                q = (s > (m_bm ? 15 : 255)) ? (m_bm ? 15 : 255) : s;
                e.raw  = (m_row == 0);
                e.data = e.raw ? q : q - lb[m_col];
                e.zero = (e.data == 0);
                e.addr = m_addr % 65536;
                e.last = (m_col == m_w) && (m_row == m_h) && (m_ch == m_c);
                sb.push_back(e);
                lb[m_col] = q;
                m_addr++;
                if (e.last) m_fed_all = 1'b1;
                if (m_col == m_w) begin
                    m_col = 0;
                    if (m_row == m_h) begin m_row = 0; m_ch++; end
                    else m_row++;
                end else begin
                    m_col++;
                end
            end
        end
    end

    task automatic configure(input int w, input int h, input int c, input bit bm, input int sh);
        @(posedge clk); #1;
        fif.cfg_valid  = 1'b1;
        fif.w_num_i    = 8'(w);
        fif.h_num_i    = 8'(h);
        fif.c_num_i    = 8'(c);
        fif.bit_mode_i = bm;
        fif.shift_i    = 4'(sh);
        @(posedge clk); #1;
        fif.cfg_valid  = 1'b0;
    endtask

    task automatic feed(input int n, input int stall_at, input int stall_len, output int cyc);
        int i = 0;
        int guard = 0;
        bit acc;
        cyc = 0;
        fif.psum_valid = 1'b1;
        fif.psum_data  = PSUM_W'(pq[0]);
        while (i < n && guard < 500) begin
            @(negedge clk);
            acc = fif.psum_ready;
            @(posedge clk); #1;
            cyc++; guard++;
            if (acc) begin
                i++;
                if (i < n) fif.psum_data = PSUM_W'(pq[i]);
                else       fif.psum_valid = 1'b0;
            end
            if (acc && i == stall_at) begin
                fif.out_ready = 1'b0;
                for (int k = 0; k < stall_len; k++) begin
                    @(negedge clk);
                    chk("stall_valid", fif.out_valid, 1);
                    chk("stall_psum_ready", fif.psum_ready, 0);
                    chk("stall_data", $signed(fif.out_data), sb[0].data);
                    chk("stall_addr", fif.out_addr, sb[0].addr);
                    @(posedge clk); #1;
                    cyc++;
                end
                fif.out_ready = 1'b1;
            end
        end
        chk("feed_beats", i, n);
        fif.psum_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (fif.layer_done) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    task automatic clear_logs();
        data_log.delete();
        raw_log.delete();
        zero_log.delete();
    endtask

    initial begin
        int cyc;
        int exp1 [8] = '{10, 20, 30, 40, 2, 0, -5, 215};
        int exp2 [4] = '{0, 1, 15, 15};
        int ezr2 [4] = '{1, 0, 0, 0};
        int exp3 [8] = '{5, 6, 2, 3, 100, 200, -10, 10};
        int raw3 [8] = '{1, 1, 0, 0, 1, 1, 0, 0};
        int exp4 [8] = '{4, 8, 12, 16, 16, 16, 16, 16};
        int exp6 [6] = '{3, 3, 3, 6, 6, 6};

        rst = 1'b1;
        fif.cfg_valid = 1'b0; fif.w_num_i = '0; fif.h_num_i = '0; fif.c_num_i = '0;
        fif.bit_mode_i = 1'b0; fif.shift_i = '0;
        fif.psum_valid = 1'b0; fif.psum_data = '0; fif.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_cfg_ready", fif.cfg_ready, 1);
        chk("rst_out_valid", fif.out_valid, 0);
        chk("rst_layer_done", fif.layer_done, 0);
        chk("rst_psum_ready", fif.psum_ready, 0);
        chk("rst_out_data", fif.out_data, 0);
        chk("rst_out_addr", fif.out_addr, 0);
        chk("rst_out_raw", fif.out_raw, 0);
        chk("rst_out_zero", fif.out_zero, 0);

        // Two rows, 8-bit, includes saturation and a zero diff.
        clear_logs();
        configure(3, 1, 0, 1'b0, 0);
        pq = '{10, 20, 30, 40, 12, 20, 25, 300};
        feed(8, -1, 0, cyc);
        chk("t1_rate", cyc, 8);
        wait_done("t1");
        chk("t1_count", data_log.size(), 8);
        for (int i = 0; i < 8 && i < data_log.size(); i++) begin
            chk("t1_data", data_log[i], exp1[i]);
            chk("t1_raw", raw_log[i], (i < 4) ? 1 : 0);
        end

        // 4-bit mode with shift and negative clamp.
        clear_logs();
        configure(3, 0, 0, 1'b1, 2);
        pq = '{-8, 4, 63, 64};
        feed(4, -1, 0, cyc);
        wait_done("t2");
        chk("t2_count", data_log.size(), 4);
        for (int i = 0; i < 4 && i < data_log.size(); i++) begin
            chk("t2_data", data_log[i], exp2[i]);
            chk("t2_zero", zero_log[i], ezr2[i]);
            chk("t2_raw", raw_log[i], 1);
        end

        // Two channels: first row of channel 1 is raw again.
        clear_logs();
        configure(1, 1, 1, 1'b0, 0);
        pq = '{5, 6, 7, 9, 100, 200, 90, 210};
        feed(8, -1, 0, cyc);
        wait_done("t3");
        chk("t3_count", data_log.size(), 8);
        for (int i = 0; i < 8 && i < data_log.size(); i++) begin
            chk("t3_data", data_log[i], exp3[i]);
            chk("t3_raw", raw_log[i], raw3[i]);
        end

        // Output stall for 5 cycles mid-row.
        clear_logs();
        configure(3, 1, 0, 1'b0, 1);
        pq = '{8, 16, 24, 32, 40, 48, 56, 64};
        feed(8, 3, 5, cyc);
        chk("t4_cycles", cyc, 13);
        wait_done("t4");
        chk("t4_count", data_log.size(), 8);
        for (int i = 0; i < 8 && i < data_log.size(); i++) begin
            chk("t4_data", data_log[i], exp4[i]);
        end

        // Reset mid-layer, then a 1x1x1 layer.
        clear_logs();
        configure(3, 1, 0, 1'b0, 0);
        pq = '{1, 2, 3, 4, 5, 6, 7, 8};
        feed(3, -1, 0, cyc);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_out_valid", fif.out_valid, 0);
        chk("t5_cfg_ready", fif.cfg_ready, 1);
        chk("t5_psum_ready", fif.psum_ready, 0);
        repeat (3) @(negedge clk);
        clear_logs();
        configure(0, 0, 0, 1'b0, 0);
        pq = '{77};
        feed(1, -1, 0, cyc);
        wait_done("t5");
        chk("t5_count", data_log.size(), 1);
        if (data_log.size() > 0) begin
            chk("t5_data", data_log[0], 77);
            chk("t5_raw", raw_log[0], 1);
        end

        // Config pulsed while busy must be ignored.
        clear_logs();
        configure(2, 1, 0, 1'b0, 0);
        fif.cfg_valid = 1'b1;
        fif.w_num_i = 8'd0; fif.h_num_i = 8'd0; fif.c_num_i = 8'd3;
        pq = '{3, 3, 3, 9, 9, 9};
        feed(6, -1, 0, cyc);
        fif.cfg_valid = 1'b0;
        wait_done("t6");
        chk("t6_count", data_log.size(), 6);
        for (int i = 0; i < 6 && i < data_log.size(); i++) begin
            chk("t6_data", data_log[i], exp6[i]);
        end
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
